regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port register file for the pipelined MIPS core. It generalises the 2R/1W file to N read and M write ports. It adds a hardwired zero register, same-cycle write-to-read bypass, and a per-register pending scoreboard so that decode can detect outstanding writebacks. It sits between decode (read and issue) and the writeback stage(s).

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of registers (at least 2)
ADDR_W, $clog2(NUM_REGS), register address width
NUM_RD, 2, number of read ports
NUM_WR, 2, number of write ports
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and issues
BYPASS, 1, 1 = a write in the current cycle is forwarded to matching reads in the same cycle

Ports:
sys_clk  in  1  clock, rising edge
sys_rst_n  in  1  reset, asynchronous, active-low
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data, combinational
rd_busy  out  NUM_RD  per read port: the register's write is still outstanding
wr_en  in  NUM_WR  per write port enable
wr_addr  in  NUM_WR*ADDR_W  packed write addresses
wr_data  in  NUM_WR*DATA_W  packed write data
iss_en  in  1  mark iss_addr as pending (instruction issued)
iss_addr  in  ADDR_W  destination register being issued
wr_conflict  out  1  registered pulse: two enabled write ports targeted the same register in the previous cycle
pend_cnt  out  ADDR_W+1  registered count of pending registers

Behaviour:
- Reset (async assert, sync release): all registers 0, all pending bits 0, wr_conflict 0, pend_cnt 0. Reset mid-operation discards in-flight writes and issues.
- Write: registers update on the rising edge of sys_clk.
  - Valid write: wr_en[j]=1 and wr_addr[j] < NUM_REGS.
  - If two or more ports target the same register, the highest-index port wins.
  - If ZERO_REG=1, writes to address 0 are ignored.
- Read: combinational.
  - Address >= NUM_REGS returns 0.
  - Address 0 returns 0 when ZERO_REG=1.
  - If BYPASS=1 and a valid write targets the read address in the same cycle, return the winning wr_data. Otherwise return the stored value (old data, no forwarding).
- Scoreboard:
  - A valid write clears pending[addr] at the edge.
  - iss_en sets pending[iss_addr] at the edge.
  - Issue and write to the same address in the same cycle: data is written and pending ends at 1 (the new producer wins).
  - Issue to address 0 (ZERO_REG=1) or to an address >= NUM_REGS is ignored.
  - Issue to an already-pending register leaves it pending. No count is kept per register.
- rd_busy[i] = pending[rd_addr[i]], except:
  - 0 when BYPASS=1 and a same-cycle valid write hits that address;
  - 0 for address 0 (ZERO_REG=1);
  - 0 for an out-of-range address.
- wr_conflict: at each edge, set to 1 if at least two valid, non-ignored writes shared an address in that cycle, else 0. Single-cycle pulse, not sticky.
- pend_cnt: popcount of the pending vector after the edge update.

Test Plan:
- Reset, then read all 32 addresses on both ports -> rd_data=0, rd_busy=0, pend_cnt=0.
- Write port 0 r5=0xDEADBEEF, same cycle read r5 -> BYPASS=1: rd_data=0xDEADBEEF immediately; BYPASS=0: 0 this cycle, 0xDEADBEEF next cycle.
- Ports 0 and 1 both write r7 (0x11, 0x22) -> r7=0x22; wr_conflict=1 for exactly one cycle.
- Write r0=0x1234 with iss_en on r0 -> rd_data(r0)=0, rd_busy=0, pend_cnt stays 0.
- Issue r3, then r4 -> pend_cnt=2, rd_busy(r3)=1. Write r3 while issuing r3 in the same cycle -> r3 updated, still busy, pend_cnt=2. Later write r3 and r4 -> pend_cnt=0.
- Issue r9, write r9=0xA5, assert sys_rst_n=0 mid-cycle -> outputs clear asynchronously: r9=0, pend_cnt=0, wr_conflict=0.

Source files
------------

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: the bus between the register file and its clients.
// The master side is decode and writeback. The slave side is the register file.
//   rd_addr / rd_data / rd_busy  : NUM_RD packed read ports. Data and busy are combinational.
//   wr_en / wr_addr / wr_data    : NUM_WR packed write ports.
//   iss_en / iss_addr            : marks a destination register as pending.
//   wr_conflict / pend_cnt       : registered status outputs.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     wr_conflict;
    logic [ADDR_W:0]          pend_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, wr_conflict, pend_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, wr_conflict, pend_cnt
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a pending-writeback scoreboard.
// The file has NUM_RD combinational read ports and NUM_WR write ports.
// When several ports write the same register, the highest-index port wins.
// Register 0 is optionally hardwired to zero.
// Writes can optionally be forwarded to reads in the same cycle.
// Ports:
//   sys_clk    rising-edge clock
//   sys_rst_n  asynchronous active-low reset. It clears the data, the pending bits and the status.
//   bus        regfile_mp_if slave modport (read, write, issue, status)
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    regfile_mp_if.slave   bus
);
    // Per-register decode of the write and issue ports.
    // Addresses at or above NUM_REGS match no register, so they are dropped automatically.
    logic [NUM_REGS-1:0] wr_hit;
    logic [NUM_REGS-1:0] wr_dup;
    logic [NUM_REGS-1:0] iss_hit;
    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_next;
    logic [DATA_W-1:0]   wr_val [NUM_REGS];
    logic [DATA_W-1:0]   reg_q  [NUM_REGS];

    logic                wr_conflict_reg;
    logic [ADDR_W:0]     pend_cnt_reg;
    logic [ADDR_W:0]     pend_cnt_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            // Register 0 takes no writes and no issues when it is hardwired to zero.
            localparam bit WRITABLE = !((ZERO_REG != 0) && (gi == 0));

            logic              hit;
            logic              dup;
            logic [DATA_W-1:0] val;
            logic [DATA_W-1:0] data_reg;
            logic              pend_reg;

            // Scan the ports in ascending order, so the last match (the highest index) wins.
            // dup is set when a second valid writer targets this register.
            always_comb begin
                hit = 1'b0;
                dup = 1'b0;
                val = '0;
                for (int j = 0; j < NUM_WR; j++) begin
                    if (WRITABLE && bus.wr_en[j] &&
                        bus.wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(gi)) begin
                        dup = dup | hit;
                        hit = 1'b1;
                        val = bus.wr_data[j*DATA_W +: DATA_W];
                    end
                end
            end

            assign iss_hit[gi] = WRITABLE && bus.iss_en && (bus.iss_addr == ADDR_W'(gi));

            // A write retires the outstanding producer.
            // A same-cycle issue names a new producer, so the issue takes priority.
            assign pend_next[gi] = (pend_reg & ~hit) | iss_hit[gi];

            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    data_reg <= '0;
                    pend_reg <= 1'b0;
                end else begin
                    if (hit) begin
                        data_reg <= val;
                    end
                    pend_reg <= pend_next[gi];
                end
            end

            assign wr_hit[gi] = hit;
            assign wr_dup[gi] = dup;
            assign wr_val[gi] = val;
            assign reg_q[gi]  = data_reg;
            assign pend_q[gi] = pend_reg;
        end

        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] data;
            logic              busy;

            assign addr = bus.rd_addr[gi*ADDR_W +: ADDR_W];

            // An out-of-range address matches nothing and reads as 0 and not busy.
            // Register 0 reads as 0 without special handling, because it is never written or issued.
            always_comb begin
                data = '0;
                busy = 1'b0;
                for (int r = 0; r < NUM_REGS; r++) begin
                    if (addr == ADDR_W'(r)) begin
                        if ((BYPASS != 0) && wr_hit[r]) begin
                            data = wr_val[r];
                        end else begin
                            data = reg_q[r];
                        end
                        busy = pend_q[r] && !((BYPASS != 0) && wr_hit[r]);
                    end
                end
            end

            assign bus.rd_data[gi*DATA_W +: DATA_W] = data;
            assign bus.rd_busy[gi]                  = busy;
        end
    endgenerate

    // pend_cnt reports the popcount of the pending state as it is after this edge.
    always_comb begin
        pend_cnt_next = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pend_cnt_next = pend_cnt_next + (ADDR_W+1)'(pend_next[r]);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_conflict_reg <= 1'b0;
            pend_cnt_reg    <= '0;
        end else begin
            wr_conflict_reg <= |wr_dup;
            pend_cnt_reg    <= pend_cnt_next;
        end
    end

    assign bus.wr_conflict = wr_conflict_reg;
    assign bus.pend_cnt    = pend_cnt_reg;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed-vector bench for regfile_mp.
// The primary DUT has BYPASS=1. A second DUT with BYPASS=0 receives the same stimulus.
// The bench checks both DUTs against hand-computed expected values.
module tb_regfile_mp;
    logic sys_clk;
    logic sys_rst_n;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bus ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bus_nb ();

    regfile_mp #(.BYPASS(1)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus_nb)
    );

    assign bus_nb.rd_addr  = bus.rd_addr;
    assign bus_nb.wr_en    = bus.wr_en;
    assign bus_nb.wr_addr  = bus.wr_addr;
    assign bus_nb.wr_data  = bus.wr_data;
    assign bus_nb.iss_en   = bus.iss_en;
    assign bus_nb.iss_addr = bus.iss_addr;

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        ie;
        logic [4:0]  ia;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_busy;   // {port1, port0}
        logic [31:0] e_nb0;    // port-0 data seen by the BYPASS=0 DUT
        logic        e_nbb0;   // port-0 busy seen by the BYPASS=0 DUT
        logic        e_conf;   // wr_conflict after the edge
        logic [5:0]  e_pend;   // pend_cnt after the edge
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic drive(input vec_t v);
        bus.wr_en    = v.we;
        bus.wr_addr  = {v.wa1, v.wa0};
        bus.wr_data  = {v.wd1, v.wd0};
        bus.iss_en   = v.ie;
        bus.iss_addr = v.ia;
        bus.rd_addr  = {v.ra1, v.ra0};
    endtask

    task automatic idle();
        bus.wr_en    = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            we     wa0   wd0           wa1   wd1    ie    ia     ra0   ra1   e_rd0         e_rd1         busy   nb0           nbb0  conf  pend
        vecs[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'h0,        1'b0, 1'b0, 6'd0};
        vecs[1]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 1'b0, 1'b0, 6'd0};
        vecs[2]  = '{2'b11, 5'd7, 32'h11,       5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd5, 32'h22,       32'hDEADBEEF, 2'b00, 32'h0,        1'b0, 1'b1, 6'd0};
        vecs[3]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd7, 32'h22,       32'h22,       2'b00, 32'h22,       1'b0, 1'b0, 6'd0};
        vecs[4]  = '{2'b01, 5'd0, 32'h1234,     5'd0, 32'h0,  1'b1, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 32'h0,        1'b0, 1'b0, 6'd0};
        vecs[5]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd3, 5'd3, 5'd4, 32'h0,        32'h0,        2'b00, 32'h0,        1'b0, 1'b0, 6'd1};
        vecs[6]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd4, 5'd3, 5'd4, 32'h0,        32'h0,        2'b01, 32'h0,        1'b1, 1'b0, 6'd2};
        vecs[7]  = '{2'b10, 5'd0, 32'h0,        5'd3, 32'h33, 1'b1, 5'd3, 5'd3, 5'd4, 32'h33,       32'h0,        2'b10, 32'h0,        1'b1, 1'b0, 6'd2};
        vecs[8]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd3, 5'd4, 32'h33,       32'h0,        2'b11, 32'h33,       1'b1, 1'b0, 6'd2};
        vecs[9]  = '{2'b11, 5'd3, 32'h44,       5'd4, 32'h55, 1'b0, 5'd0, 5'd3, 5'd4, 32'h44,       32'h55,       2'b00, 32'h33,       1'b1, 1'b0, 6'd0};
        vecs[10] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd3, 5'd4, 32'h44,       32'h55,       2'b00, 32'h44,       1'b0, 1'b0, 6'd0};
        vecs[11] = '{2'b11, 5'd0, 32'h1,        5'd0, 32'h2,  1'b0, 5'd0, 5'd0, 5'd7, 32'h0,        32'h22,       2'b00, 32'h0,        1'b0, 1'b0, 6'd0};
        vecs[12] = '{2'b10, 5'd7, 32'h77,       5'd7, 32'h99, 1'b0, 5'd0, 5'd7, 5'd7, 32'h99,       32'h99,       2'b00, 32'h22,       1'b0, 1'b0, 6'd0};
        vecs[13] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd5, 32'h99,       32'hDEADBEEF, 2'b00, 32'h99,       1'b0, 1'b0, 6'd0};

        sys_rst_n   = 1'b0;
        bus.rd_addr = '0;
        idle();
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;

        // Reset state: every address on both ports reads zero and not busy.
        check("reset_pend_cnt", 32'(bus.pend_cnt), 32'd0);
        check("reset_wr_conflict", 32'(bus.wr_conflict), 32'd0);
        for (int a = 0; a < 32; a++) begin
            bus.rd_addr = {5'(31 - a), 5'(a)};
            #1;
            check($sformatf("reset_rd0_a%0d", a), bus.rd_data[31:0], 32'h0);
            check($sformatf("reset_rd1_a%0d", 31 - a), bus.rd_data[63:32], 32'h0);
            check($sformatf("reset_busy_a%0d", a), 32'(bus.rd_busy), 32'h0);
        end
        $display("reset sweep done: 32 addresses on both ports");

        @(posedge sys_clk);
        #1;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #2;
            check($sformatf("v%0d_rd0", i), bus.rd_data[31:0], vecs[i].e_rd0);
            check($sformatf("v%0d_rd1", i), bus.rd_data[63:32], vecs[i].e_rd1);
            check($sformatf("v%0d_busy", i), 32'(bus.rd_busy), 32'(vecs[i].e_busy));
            check($sformatf("v%0d_nobyp_rd0", i), bus_nb.rd_data[31:0], vecs[i].e_nb0);
            check($sformatf("v%0d_nobyp_busy0", i), 32'(bus_nb.rd_busy[0]), 32'(vecs[i].e_nbb0));
            @(posedge sys_clk);
            #1;
            check($sformatf("v%0d_wr_conflict", i), 32'(bus.wr_conflict), 32'(vecs[i].e_conf));
            check($sformatf("v%0d_pend_cnt", i), 32'(bus.pend_cnt), 32'(vecs[i].e_pend));
            $display("vec %0d: we=%b rd0=0x%h rd1=0x%h busy=%b conflict=%0d pend=%0d",
                     i, vecs[i].we, bus.rd_data[31:0], bus.rd_data[63:32], bus.rd_busy,
                     bus.wr_conflict, bus.pend_cnt);
        end

        // Mid-cycle asynchronous reset.
        // Build up state in r9 first: conflicting writes plus an issue in the same cycle.
        bus.wr_en    = 2'b11;
        bus.wr_addr  = {5'd9, 5'd9};
        bus.wr_data  = {32'hA5, 32'hA4};
        bus.iss_en   = 1'b1;
        bus.iss_addr = 5'd9;
        bus.rd_addr  = {5'd9, 5'd9};
        @(posedge sys_clk);
        #1;
        idle();
        #1;
        check("pre_rst_rd9", bus.rd_data[31:0], 32'hA5);
        check("pre_rst_busy9", 32'(bus.rd_busy), 32'h3);
        check("pre_rst_pend_cnt", 32'(bus.pend_cnt), 32'd1);
        check("pre_rst_wr_conflict", 32'(bus.wr_conflict), 32'd1);
        #1;
        sys_rst_n = 1'b0;
        #1;
        check("async_rst_rd9", bus.rd_data[31:0], 32'h0);
        check("async_rst_busy9", 32'(bus.rd_busy), 32'h0);
        check("async_rst_pend_cnt", 32'(bus.pend_cnt), 32'd0);
        check("async_rst_wr_conflict", 32'(bus.wr_conflict), 32'd0);
        $display("async reset: rd9=0x%h pend=%0d conflict=%0d",
                 bus.rd_data[31:0], bus.pend_cnt, bus.wr_conflict);

        // A write and an issue presented while reset is held must be discarded.
        bus.wr_en    = 2'b01;
        bus.wr_addr  = {5'd0, 5'd9};
        bus.wr_data  = {32'h0, 32'hBAD};
        bus.iss_en   = 1'b1;
        bus.iss_addr = 5'd9;
        @(posedge sys_clk);
        #1;
        idle();
        sys_rst_n = 1'b1;
        #1;
        check("post_rst_rd9", bus.rd_data[31:0], 32'h0);
        check("post_rst_busy9", 32'(bus.rd_busy), 32'h0);
        check("post_rst_pend_cnt", 32'(bus.pend_cnt), 32'd0);
        $display("reset release: rd9=0x%h busy=%b pend=%0d",
                 bus.rd_data[31:0], bus.rd_busy, bus.pend_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
